// File: rtl/lab_sweep_pkg.sv
// lab_sweep_pkg: shared FSM state and vector-ordering definitions for the sweeper.
package lab_sweep_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam logic ORDER_BIN = 1'b0;
  localparam logic ORDER_GRAY = 1'b1;
endpackage

// File: rtl/lab_sweep_order.sv
// lab_sweep_order: maps a sweep index to the applied vector in binary or Gray order.
module lab_sweep_order
  import lab_sweep_pkg::*;
#(
  parameter int N_IN = 4
) (
  input  logic [N_IN-1:0] idx,
  input  logic            mode,
  output logic [N_IN-1:0] vec
);
  assign vec = (mode == ORDER_GRAY) ? idx ^ (idx >> 1) : idx;
endmodule

// File: rtl/lab_vector_sweeper.sv
// lab_vector_sweeper: exhaustive stimulus engine that checks a DUT against a truth table.
module lab_vector_sweeper
  import lab_sweep_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int M_OUT = 1,
  parameter int DWELL = 4,
  parameter logic [(2**N_IN)*M_OUT-1:0] EXPECT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             gray,
  input  logic [M_OUT-1:0] dut_f,
  output logic [N_IN-1:0]  vec,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_IN:0]    err_count,
  output logic [N_IN-1:0]  fail_vec,
  output logic             fail_seen
);
  localparam int DW = DWELL > 1 ? $clog2(DWELL) : 1;
  localparam logic [N_IN:0] LAST = (N_IN+1)'(2**N_IN - 1);
  state_t state;
  logic mode_r;
  logic [N_IN:0] idx;
  logic [DW-1:0] dwell;
  logic [N_IN-1:0] ord_vec;
  logic [M_OUT-1:0] exp_f;
  logic sample, mismatch;
  lab_sweep_order #(.N_IN(N_IN)) u_order (.idx(idx[N_IN-1:0]), .mode(mode_r), .vec(ord_vec));
  assign vec = (state == IDLE) ? '0 : ord_vec;
  assign busy = state == RUN;
  assign done = state == DONE;
  assign pass = done && err_count == '0;
  // table lookup uses the applied vector so Gray order checks the right entry
  assign exp_f = EXPECT[int'(vec) * M_OUT +: M_OUT];
  assign sample = busy && dwell == DW'(DWELL - 1);
  assign mismatch = sample && dut_f != exp_f;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mode_r <= ORDER_BIN;
      idx <= '0;
      dwell <= '0;
      err_count <= '0;
      fail_vec <= '0;
      fail_seen <= 1'b0;
    end else if (abort) begin
      state <= IDLE;
    end else if (start && !busy) begin
      state <= RUN;
      mode_r <= gray;
      idx <= '0;
      dwell <= '0;
      err_count <= '0;
      fail_vec <= '0;
      fail_seen <= 1'b0;
    end else if (busy) begin
      if (mismatch) begin
        err_count <= err_count + 1'b1;
        if (!fail_seen) begin
          fail_vec <= vec;
          fail_seen <= 1'b1;
        end
      end
      if (sample) begin
        dwell <= '0;
        if (idx == LAST) state <= DONE;
        else idx <= idx + 1'b1;
      end else begin
        dwell <= dwell + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_lab_vector_sweeper.sv
// tb_lab_vector_sweeper: checks two sweeper instances (DWELL 4 and 1) against a closed-form model.
module tb_lab_vector_sweeper;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] start = '0, abort = '0, gray = '0;
  logic [1:0] dut_f, busy, done, pass, fail_seen;
  logic [1:0][3:0] vec, fail_vec;
  logic [1:0][4:0] err_count;
  logic [15:0] tbl [2] = '{16'h6996, 16'h6196};
  int dw [2] = '{4, 1};
  int rmode [2] = '{0, 2};
  int tests = 0, fails = 0;
  bit chk_en = 1'b0;
  bit act [2];
  bit md [2];
  int n [2] = '{0, 0};
  logic [15:0] mm [2];
  logic [3:0] pv;
  bit pb = 1'b0;

  always #5 clk = ~clk;

  // 0 parity, 1 stuck-at-0, 2 echo the table, 3 parity with v=B inverted
  function automatic logic resp(int r, logic [15:0] t, logic [3:0] v);
    return r == 0 ? ^v : r == 1 ? 1'b0 : r == 2 ? t[v] : (^v) ^ (v == 4'hB);
  endfunction

  function automatic logic [15:0] mism(int r, logic [15:0] t);
    logic [15:0] m;
    for (int v = 0; v < 16; v++) m[v] = resp(r, t, 4'(v)) != t[v];
    return m;
  endfunction

  function automatic logic [3:0] ord(int k, bit g);
    logic [3:0] x;
    x = 4'(k);
    return g ? x ^ (x >> 1) : x;
  endfunction

  assign dut_f[0] = resp(rmode[0], tbl[0], vec[0]);
  assign dut_f[1] = resp(rmode[1], tbl[1], vec[1]);

  lab_vector_sweeper #(.N_IN(4), .M_OUT(1), .DWELL(4), .EXPECT(16'h6996)) u0 (
    .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]), .gray(gray[0]),
    .dut_f(dut_f[0]), .vec(vec[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_count(err_count[0]), .fail_vec(fail_vec[0]), .fail_seen(fail_seen[0]));

  lab_vector_sweeper #(.N_IN(4), .M_OUT(1), .DWELL(1), .EXPECT(16'h6196)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]), .gray(gray[1]),
    .dut_f(dut_f[1]), .vec(vec[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_count(err_count[1]), .fail_vec(fail_vec[1]), .fail_seen(fail_seen[1]));

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endtask

  // model: n counts edges since the start edge; results follow from n alone
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        act[i] <= 1'b0;
        n[i] <= 0;
      end else if (abort[i]) begin
        act[i] <= 1'b0;
      end else if (start[i] && !(act[i] && n[i] < 16 * dw[i])) begin
        act[i] <= 1'b1;
        n[i] <= 0;
        md[i] <= gray[i];
        mm[i] <= mism(rmode[i], tbl[i]);
      end else if (act[i] && n[i] < 16 * dw[i]) begin
        n[i] <= n[i] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        int m;
        logic [3:0] ev, ef;
        logic [4:0] ee;
        logic es, eb, ed;
        m = n[i] / dw[i];
        if (m > 16) m = 16;
        ee = '0;
        ef = '0;
        es = 1'b0;
        for (int k = 0; k < m; k++) begin
          if (mm[i][ord(k, md[i])]) begin
            if (!es) ef = ord(k, md[i]);
            es = 1'b1;
            ee = ee + 5'd1;
          end
        end
        eb = act[i] && n[i] < 16 * dw[i];
        ed = act[i] && !eb;
        ev = act[i] ? ord(m > 15 ? 15 : m, md[i]) : 4'h0;
        chk($sformatf("u%0d.vec", i), 32'(vec[i]), 32'(ev));
        chk($sformatf("u%0d.busy", i), 32'(busy[i]), 32'(eb));
        chk($sformatf("u%0d.done", i), 32'(done[i]), 32'(ed));
        chk($sformatf("u%0d.pass", i), 32'(pass[i]), 32'(ed && ee == 0));
        chk($sformatf("u%0d.err_count", i), 32'(err_count[i]), 32'(ee));
        chk($sformatf("u%0d.fail_vec", i), 32'(fail_vec[i]), 32'(ef));
        chk($sformatf("u%0d.fail_seen", i), 32'(fail_seen[i]), 32'(es));
      end
      if (busy[1] && pb && md[1]) chk("u1.gray_step", 32'($countones(vec[1] ^ pv)), 1);
      pb <= busy[1];
      pv <= vec[1];
    end
  end

  task automatic go(int i, bit g);
    @(posedge clk);
    #1 start[i] = 1'b1;
    gray[i] = g;
    @(posedge clk);
    #1 start[i] = 1'b0;
  endtask

  task automatic wait_done(int i);
    int c = 0;
    while (!done[i] && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("done_timeout", 32'(done[i]), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy[0]), 0);
    chk("rst_err", 32'(err_count[0]), 0);
    // binary sweep, correct DUT: done exactly at E0+64
    go(0, 1'b0);
    @(negedge clk);
    chk("bin_first_vec", 32'(vec[0]), 0);
    repeat (63) @(negedge clk);
    chk("bin_done_e63", 32'(done[0]), 0);
    chk("bin_vec_e63", 32'(vec[0]), 15);
    @(negedge clk);
    chk("bin_done_e64", 32'(done[0]), 1);
    chk("bin_pass", 32'(pass[0]), 1);
    // stuck-at-0 DUT
    rmode[0] = 1;
    go(0, 1'b0);
    wait_done(0);
    chk("stuck_err", 32'(err_count[0]), 8);
    chk("stuck_fail_vec", 32'(fail_vec[0]), 1);
    chk("stuck_pass", 32'(pass[0]), 0);
    // single bad response at v=B, binary then Gray
    rmode[0] = 3;
    go(0, 1'b0);
    wait_done(0);
    chk("b_bin_err", 32'(err_count[0]), 1);
    chk("b_bin_fv", 32'(fail_vec[0]), 11);
    go(0, 1'b1);
    wait_done(0);
    chk("b_gray_err", 32'(err_count[0]), 1);
    chk("b_gray_fv", 32'(fail_vec[0]), 11);
    // Gray order, DWELL=1, DUT matches its table
    go(1, 1'b1);
    @(negedge clk);
    chk("gray_v0", 32'(vec[1]), 0);
    @(negedge clk);
    chk("gray_v1", 32'(vec[1]), 1);
    @(negedge clk);
    chk("gray_v2", 32'(vec[1]), 3);
    @(negedge clk);
    chk("gray_v3", 32'(vec[1]), 2);
    @(negedge clk);
    chk("gray_v4", 32'(vec[1]), 6);
    repeat (11) @(negedge clk);
    chk("gray_done_e15", 32'(done[1]), 0);
    @(negedge clk);
    chk("gray_done_e16", 32'(done[1]), 1);
    chk("gray_last_vec", 32'(vec[1]), 8);
    chk("gray_pass", 32'(pass[1]), 1);
    // table with a wrong entry at v=B against a correct parity DUT
    rmode[1] = 0;
    go(1, 1'b0);
    wait_done(1);
    chk("tbl_bin_err", 32'(err_count[1]), 1);
    chk("tbl_bin_fv", 32'(fail_vec[1]), 11);
    go(1, 1'b1);
    wait_done(1);
    chk("tbl_gray_err", 32'(err_count[1]), 1);
    chk("tbl_gray_fv", 32'(fail_vec[1]), 11);
    // abort at edge E0+20 with stuck DUT: vectors 0..3 compared -> errors at 1 and 2
    rmode[0] = 1;
    go(0, 1'b0);
    repeat (19) @(posedge clk);
    #1 abort[0] = 1'b1;
    @(posedge clk);
    #1 abort[0] = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy[0]), 0);
    chk("abort_vec", 32'(vec[0]), 0);
    chk("abort_err_kept", 32'(err_count[0]), 2);
    rmode[0] = 0;
    go(0, 1'b0);
    wait_done(0);
    chk("after_abort_pass", 32'(pass[0]), 1);
    // start while busy must not move done off E0+64
    go(0, 1'b0);
    repeat (9) @(posedge clk);
    #1 start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    repeat (54) @(negedge clk);
    chk("restart_ign_e63", 32'(done[0]), 0);
    @(negedge clk);
    chk("restart_ign_e64", 32'(done[0]), 1);
    // reset mid-sweep with mismatches already counted
    rmode[0] = 1;
    go(0, 1'b0);
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_err", 32'(err_count[0]), 0);
    chk("rst_mid_seen", 32'(fail_seen[0]), 0);
    chk("rst_mid_busy", 32'(busy[0]), 0);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lab_vector_sweeper.md
# lab_vector_sweeper

Synthesizable, self-checking exhaustive stimulus engine for small combinational lab DUTs. Drives every one of the 2^N_IN input combinations onto the DUT, holds each vector for a programmable dwell, samples the DUT outputs and compares them against a parameterised expected truth table. Counts mismatches and reports pass/fail. Sits beside a gate-level lab module inside the bench or on the FPGA top, replacing hand-written per-vector stimulus.

## Interface
- N_IN, 4, number of DUT inputs; vector width (1..8)
- M_OUT, 1, number of DUT outputs compared per vector (1..8)
- DWELL, 4, clock cycles each vector is held (>=1)
- EXPECT, 0, expected truth table, (2^N_IN)*M_OUT bits; entry for input value v is EXPECT[v*M_OUT +: M_OUT]
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle request to begin a sweep
- abort  in  1  stop current sweep, return to IDLE
- gray  in  1  ordering mode, sampled with start: 0 binary, 1 Gray code
- dut_f  in  M_OUT  DUT response
- vec  out  N_IN  vector driven to DUT
- busy  out  1  sweep in progress
- done  out  1  sweep finished, results valid
- pass  out  1  done and zero mismatches
- err_count  out  N_IN+1  number of mismatching vectors
- fail_vec  out  N_IN  applied vector value of the first mismatch
- fail_seen  out  1  at least one mismatch recorded

## Operation
- States: IDLE, RUN, DONE.
- IDLE: busy=0. start=1 -> RUN; latch gray into mode_r; clear idx, dwell, err_count, fail_vec, fail_seen, pass, done.
- RUN: busy=1. vec = idx (binary) or idx ^ (idx>>1) (Gray). Dwell counter 0..DWELL-1 per vector.
- On the cycle with dwell==DWELL-1: compare dut_f against EXPECT entry indexed by vec (the applied value, not idx). Mismatch -> err_count+1; if fail_seen==0, capture fail_vec=vec, set fail_seen.
- After that compare: if idx==2^N_IN-1 -> DONE; else idx+1, dwell=0.
- DONE: busy=0, done=1, pass=(err_count==0), vec holds last applied vector. start=1 -> new sweep (as from IDLE).
- start in RUN ignored. abort has priority over start; abort in RUN or DONE -> IDLE, vec=0, done=0, pass=0; err_count/fail_* retained until next start.
- err_count maximum 2^N_IN, fits N_IN+1 bits; no saturation required.
- idx is N_IN+1 bits internally so the terminal compare does not wrap.

## Timing
- Reset values: vec=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, fail_seen=0, state IDLE. rst mid-sweep aborts immediately at that edge; no result is reported.
- start sampled at edge E0 -> from E0 busy=1, vec=first vector.
- Vector k held from edge E0+k*DWELL to E0+(k+1)*DWELL; dut_f sampled on the edge ending its dwell, giving the DUT DWELL-1 full cycles plus one cycle of combinational settling.
- done/pass valid from edge E0 + 2^N_IN*DWELL; busy falls on that edge.
- DWELL=1: compare every cycle, vector advances every cycle.
- Mismatch on the last vector is counted and is visible in err_count/pass on the same edge that done rises.

## Structure
- Package lab_sweep_pkg: state enum (IDLE, RUN, DONE), order-mode constants ORDER_BIN=0, ORDER_GRAY=1.
- Sub-module lab_sweep_order: combinational index-to-vector map (binary/Gray), N_IN parameter.
- Top: FSM, dwell counter, index counter, comparator, result registers.

## Test plan
- N_IN=4, M_OUT=1, DWELL=4, DUT = A^B^C^D, EXPECT=16'h6996, binary -> vec 0..15 in order, each 4 cycles; done at E0+64; pass=1, err_count=0.
- Same, DUT stuck-at-0 -> err_count=8, fail_vec=4'h1, fail_seen=1, pass=0.
- Gray mode, DWELL=1, DUT correct -> vec sequence 0,1,3,2,6,... ends at 4'h8; every transition changes exactly one bit; pass=1 at E0+16.
- Expected table with a single wrong entry at v=4'hB -> err_count=1, fail_vec=4'hB, in both binary and Gray modes.
- abort at cycle 20 of a sweep -> IDLE next edge, busy=0, done=0, vec=0; subsequent start runs a full clean sweep to pass=1.
- rst asserted mid-sweep, start pulsed while busy -> all outputs at reset values after rst edge; start during RUN does not restart (done timing unchanged).
